pulse_bram_arbiter: RTL and testbench

Shares the single-port pulse BRAM between two requesters: the pulse generator (read-modify-write accumulation of the neutron pulse table) and the playout reader (streams accumulated samples to the output path). Sits between both requesters and the pulse BRAM instance and owns its `ena`/`we`/`addr`/`din` pins. It provides per-requester request/grant handshakes, a read-modify-write lock for the generator, bounded priority for playout, and optional clear-on-read for playout.

---
 rtl/pulse_bram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_pulse_bram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_bram_arbiter.sv
`default_nettype none
//============================================================================
// Module   : pulse_bram_arbiter
// Purpose  : Shares the single-port pulse BRAM between the pulse generator
//            (requester A, read-modify-write accumulation with an optional
//            lock) and the playout reader (requester B, streaming reads).
//            This block owns the BRAM ena/we/addr/din pins.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   B_MAX_RUN    : playout grants allowed in a row while A waits (1..15)
//   LOCK_TIMEOUT : cycles an A lock may be held before forced release (2..255)
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a_req/a_we/a_lock/a_addr/a_wdata -> a_gnt (comb), a_rvalid/a_rdata
//   b_req/b_addr                -> b_gnt (comb), b_rvalid/b_rdata
//   bram_ena/we/addr/din        : registered BRAM command pins
//   bram_dout                   : BRAM read data, valid the cycle after a read
//   lock_err                    : sticky, set when an A lock times out
// Build option
//   PULSE_ARB_CLR_ON_READ_EN    : each granted playout read is followed by a
//                                 write of 0 to the same word (clear-on-read)
//============================================================================
module pulse_bram_arbiter #(
    parameter int B_MAX_RUN    = 4,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_lock,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        bram_ena,
    output logic        bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout,
    output logic        lock_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_A_LOCK = 2'd1;
`ifdef PULSE_ARB_CLR_ON_READ_EN
    localparam logic [1:0] c_B_CLR  = 2'd2;
`endif
    localparam logic [3:0] c_RUN_MAX = 4'(B_MAX_RUN);
    localparam logic [7:0] c_TIMEOUT = 8'(LOCK_TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_b_run;
    logic [7:0] r_lock_tmr;
    logic       r_a_rd_pend;
    logic       r_b_rd_pend;
    logic       w_a_gnt;
    logic       w_b_gnt;
    logic       w_timeout;

    // Read data is the raw BRAM output; rvalid qualifies which requester owns it.
    assign a_rdata = bram_dout;
    assign b_rdata = bram_dout;

    // Grants are combinational; masked while reset is asserted.
    assign a_gnt = w_a_gnt & rst_n;
    assign b_gnt = w_b_gnt & rst_n;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_a_gnt && !a_we && a_lock) begin
                    w_state_nxt = c_A_LOCK;
                end
`ifdef PULSE_ARB_CLR_ON_READ_EN
                else if (w_b_gnt) begin
                    w_state_nxt = c_B_CLR;
                end
`endif
            end
            c_A_LOCK: begin
                // A write always ends the lock, whatever a_lock says.
                if (w_timeout || (w_a_gnt && a_we) || (!a_req && !a_lock)) begin
                    w_state_nxt = c_IDLE;
                end
            end
`ifdef PULSE_ARB_CLR_ON_READ_EN
            c_B_CLR: begin
                w_state_nxt = c_IDLE;
            end
`endif
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Grant / output logic
    //------------------------------------------------------------------------
    always_comb begin
        w_a_gnt   = 1'b0;
        w_b_gnt   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Playout has priority unless it has used up its run while A waits.
                if (a_req && (!b_req || (r_b_run == c_RUN_MAX))) begin
                    w_a_gnt = 1'b1;
                end else if (b_req) begin
                    w_b_gnt = 1'b1;
                end
            end
            c_A_LOCK: begin
                if (r_lock_tmr == c_TIMEOUT) begin
                    w_timeout = 1'b1;
                end else begin
                    w_a_gnt = a_req;
                end
            end
            default: begin
                w_a_gnt = 1'b0;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // BRAM command pins, read-valid pipeline, run counter, lock timer
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_ena    <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= 32'd0;
            bram_din    <= 32'd0;
            r_a_rd_pend <= 1'b0;
            r_b_rd_pend <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            r_b_run     <= 4'd0;
            r_lock_tmr  <= 8'd0;
            lock_err    <= 1'b0;
        end else begin
            bram_ena <= w_a_gnt | w_b_gnt;
            bram_we  <= w_a_gnt & a_we;
            if (w_a_gnt) begin
                bram_addr <= a_addr;
                if (a_we) begin
                    bram_din <= a_wdata;
                end
            end else if (w_b_gnt) begin
                bram_addr <= b_addr;
            end
`ifdef PULSE_ARB_CLR_ON_READ_EN
            // bram_addr still holds the playout address from the previous cycle.
            if (r_state == c_B_CLR) begin
                bram_ena <= 1'b1;
                bram_we  <= 1'b1;
                bram_din <= 32'd0;
            end
`endif
            r_a_rd_pend <= w_a_gnt & ~a_we;
            r_b_rd_pend <= w_b_gnt;
            a_rvalid    <= r_a_rd_pend;
            b_rvalid    <= r_b_rd_pend;

            if (w_a_gnt || !a_req) begin
                r_b_run <= 4'd0;
            end else if (w_b_gnt) begin
                r_b_run <= r_b_run + 4'd1;
            end

            // Timer sits at 0 outside the lock, so it starts from 0 on entry.
            if (r_state == c_A_LOCK) begin
                r_lock_tmr <= r_lock_tmr + 8'd1;
            end else begin
                r_lock_tmr <= 8'd0;
            end

            if (w_timeout) begin
                lock_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_bram_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_pulse_bram_arbiter
// Purpose  : Self-checking bench for pulse_bram_arbiter with a BRAM model,
//            a cycle-level reference model and directed scenarios.
// Revision : 1.0 - initial release
//============================================================================
module tb_pulse_bram_arbiter;

    localparam int B_MAX_RUN    = 4;
    localparam int LOCK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0;
    logic [31:0] b_addr = 32'd0;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic        bram_ena, bram_we;
    logic [31:0] bram_addr, bram_din;
    logic [31:0] bram_dout = 32'd0;
    logic        lock_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_bram_arbiter #(
        .B_MAX_RUN   (B_MAX_RUN),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_lock   (a_lock),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .bram_ena (bram_ena),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_dout(bram_dout),
        .lock_err (lock_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h3F59AD43;
        if (i == 3) return 32'h3DA339C1;
        return 32'h1000_0000 + 32'(i);
    endfunction

    //------------------------------------------------------------------------
    // BRAM model: single port, read data valid the cycle after the command
    //------------------------------------------------------------------------
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (bram_ena) begin
            if (bram_we) mem[bram_addr[7:2]] = bram_din;
            else         bram_dout = mem[bram_addr[7:2]];
        end
    end

    //------------------------------------------------------------------------
    // Reference model + per-cycle compare (evaluated mid-cycle)
    //------------------------------------------------------------------------
    logic [31:0] ref_mem [0:63];
    bit          ref_init = 1'b0;
    int          m_run = 0, m_timer = 0;
    bit          m_locked = 0, m_clr = 0, m_err = 0;
    bit          e_ena = 0, e_we = 0, e_src_b = 0, e_arv = 0, e_brv = 0;
    logic [31:0] e_addr = 0, e_din = 0, e_rdata = 0;

    always @(negedge clk) begin : p_model
        bit          ga, gb, tmo, n_arv, n_brv;
        logic [31:0] n_rdata;
        if (!ref_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            chk("rst_outs", {23'd0, bram_ena, bram_we, a_gnt, b_gnt, a_rvalid, b_rvalid, lock_err,
                             |bram_addr, |bram_din}, 32'd0);
            m_run = 0; m_timer = 0; m_locked = 0; m_clr = 0; m_err = 0;
            e_ena = 0; e_we = 0; e_src_b = 0; e_arv = 0; e_brv = 0;
            e_addr = 0; e_din = 0;
        end else begin
            ga = 0; gb = 0; tmo = 0;
            if (m_clr) begin
                ga = 0;
            end else if (m_locked) begin
                if (m_timer == LOCK_TIMEOUT) tmo = 1;
                else ga = a_req;
            end else if (a_req && (!b_req || m_run == B_MAX_RUN)) begin
                ga = 1;
            end else begin
                gb = b_req;
            end

            chk("m_a_gnt", {31'd0, a_gnt}, {31'd0, ga});
            chk("m_b_gnt", {31'd0, b_gnt}, {31'd0, gb});
            chk("m_bram_ctl", {30'd0, bram_ena, bram_we}, {30'd0, e_ena, e_we});
            chk("m_bram_addr", bram_addr, e_addr);
            chk("m_bram_din", bram_din, e_din);
            chk("m_rvalid", {30'd0, a_rvalid, b_rvalid}, {30'd0, e_arv, e_brv});
            if (e_arv) chk("m_a_rdata", a_rdata, e_rdata);
            if (e_brv) chk("m_b_rdata", b_rdata, e_rdata);
            chk("m_lock_err", {31'd0, lock_err}, {31'd0, m_err});

            // Effect of the command currently on the pins.
            n_arv = e_ena && !e_we && !e_src_b;
            n_brv = e_ena && !e_we && e_src_b;
            n_rdata = e_rdata;
            if (e_ena && e_we) ref_mem[e_addr[7:2]] = e_din;
            else if (e_ena)    n_rdata = ref_mem[e_addr[7:2]];
            e_arv = n_arv; e_brv = n_brv; e_rdata = n_rdata;

            // Command for the next cycle.
            if (ga) begin
                e_ena = 1; e_we = a_we; e_addr = a_addr; e_src_b = 0;
                if (a_we) e_din = a_wdata;
            end else if (gb) begin
                e_ena = 1; e_we = 0; e_addr = b_addr; e_src_b = 1;
            end else if (m_clr) begin
                e_ena = 1; e_we = 1; e_din = 32'd0;
            end else begin
                e_ena = 0; e_we = 0;
            end

            if (ga || !a_req) m_run = 0;
            else if (gb)      m_run = m_run + 1;

            if (tmo) begin
                m_locked = 0; m_err = 1;
            end else if (m_locked) begin
                if ((ga && a_we) || (!a_req && !a_lock)) m_locked = 0;
                m_timer = m_timer + 1;
            end else if (ga && !a_we && a_lock) begin
                m_locked = 1; m_timer = 0;
            end
`ifdef PULSE_ARB_CLR_ON_READ_EN
            m_clr = gb;
`else
            m_clr = 0;
`endif
        end
    end

    //------------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    //------------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] seq;
        int         cnt;

        // Reset; a request during reset must not be granted.
        a_req = 1; a_we = 0; a_addr = 32'h4;
        repeat (2) @(negedge clk);
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_ena", {31'd0, bram_ena}, 32'd0);

        // T1: basic read latency.
        tick; rst_n = 1;
        @(negedge clk); chk("t1_a_gnt", {31'd0, a_gnt}, 32'd1);
        tick; a_req = 0;
        @(negedge clk);
        chk("t1_ena_we", {30'd0, bram_ena, bram_we}, 32'd2);
        chk("t1_addr", bram_addr, 32'h4);
        tick;
        @(negedge clk);
        chk("t1_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t1_rdata", a_rdata, 32'h3F59AD43);

        // T2: bounded playout priority.
        tick; a_req = 1; a_we = 0; a_addr = 32'h8; a_lock = 0; b_req = 1; b_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq[i] = a_gnt;
        end
`ifndef PULSE_ARB_CLR_ON_READ_EN
        chk("t2_grant_seq", {22'd0, seq}, 32'b10_0001_0000);
`endif
        tick; a_req = 0; b_req = 0;
        tick;

        // T3: locked read-modify-write with playout waiting.
        a_req = 1; a_we = 0; a_lock = 1; a_addr = 32'h8;
        @(negedge clk); chk("t3_lock_gnt", {31'd0, a_gnt}, 32'd1);
        tick; a_req = 0; b_req = 1; b_addr = 32'h10;
        @(negedge clk); chk("t3_b_held", {31'd0, b_gnt}, 32'd0);
        tick; a_req = 1; a_we = 1; a_wdata = 32'h3F800000; a_lock = 0;
        @(negedge clk);
        chk("t3_wr_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        chk("t3_old_rdata", a_rdata, 32'h1000_0002);
        tick; a_req = 0; a_we = 0;
        @(negedge clk); chk("t3_b_resume", {31'd0, b_gnt}, 32'd1);
        tick; b_req = 0;
        tick; tick;
        chk("t3_mem_word8", mem[2], 32'h3F800000);

        // T4: lock timeout.
        a_req = 1; a_we = 0; a_lock = 1; a_addr = 32'h14;
        @(negedge clk); chk("t4_lock_gnt", {31'd0, a_gnt}, 32'd1);
        tick; a_req = 0; b_req = 1; b_addr = 32'h10;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_gnt) break;
            cnt++;
        end
        chk("t4_lock_cycles", cnt, LOCK_TIMEOUT + 1);
        chk("t4_lock_err", {31'd0, lock_err}, 32'd1);
        tick; b_req = 0; a_lock = 0;
        repeat (3) tick;
        @(negedge clk); chk("t4_sticky", {31'd0, lock_err}, 32'd1);

`ifdef PULSE_ARB_CLR_ON_READ_EN
        // T5: clear-on-read.
        tick; b_req = 1; b_addr = 32'hC;
        @(negedge clk); chk("t5_b_gnt", {31'd0, b_gnt}, 32'd1);
        tick; b_req = 0;
        tick;
        @(negedge clk);
        chk("t5_rdata", b_rdata, 32'h3DA339C1);
        chk("t5_clr_ctl", {30'd0, bram_ena, bram_we}, 32'd3);
        chk("t5_clr_addr", bram_addr, 32'hC);
        chk("t5_clr_din", bram_din, 32'd0);
        tick; b_req = 1;
        @(negedge clk); chk("t5_regnt", {31'd0, b_gnt}, 32'd1);
        tick; b_req = 0;
        tick;
        @(negedge clk); chk("t5_reread", b_rdata, 32'd0);
`endif

        // T6: reset while locked with a read in flight.
        tick; a_req = 1; a_we = 0; a_lock = 1; a_addr = 32'h18;
        @(negedge clk); chk("t6_lock_gnt", {31'd0, a_gnt}, 32'd1);
        tick;
        @(negedge clk); chk("t6_locked_rd", {31'd0, a_gnt}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_ctl", {25'd0, bram_ena, bram_we, a_gnt, b_gnt, a_rvalid, b_rvalid, lock_err}, 32'd0);
        chk("t6_async_addr", bram_addr, 32'd0);
        a_req = 0; a_lock = 0;
        tick;
        @(negedge clk);
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rvalid", {31'd0, a_rvalid}, 32'd0);
        end
        tick; b_req = 1; b_addr = 32'h20;
        @(negedge clk); chk("t6_idle_b_gnt", {31'd0, b_gnt}, 32'd1);
        tick; b_req = 0;
        repeat (3) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
